// File: rtl/nlfsr_seed_loader_if.sv
// Seed handshake between the lane control (master) and the NLFSR seed loader (slave).
interface nlfsr_seed_loader_if #(
    parameter int SEED_W = 16
);
    logic [SEED_W-1:0] seed;
    logic              seed_valid;
    logic              seed_ready;

    modport master (
        output seed,
        output seed_valid,
        input  seed_ready
    );

    modport slave (
        input  seed,
        input  seed_valid,
        output seed_ready
    );
endinterface

// File: rtl/nlfsr_seed_loader.sv
// Shifts a parallel seed LSB-first into an NLFSR, holds it in init feedback, then releases it to run.
// Optional build macro NLFSR_SEED_ZERO_GUARD_EN: an all-zero seed becomes 1 and zero_seed_flag pulses.
module nlfsr_seed_loader #(
    parameter int SEED_W      = 16,
    parameter int INIT_CYCLES = 32
) (
    input  logic               clk,
    input  logic               rst,
    nlfsr_seed_loader_if.slave seed_if,
    input  logic               run_en,
    output logic               d_o,
    output logic               load_o,
    output logic               init_o,
    output logic               ce_o,
    output logic               running,
    output logic               busy
`ifdef NLFSR_SEED_ZERO_GUARD_EN
    ,
    output logic               zero_seed_flag
`endif
);
    localparam int CNT_MAX = (SEED_W > INIT_CYCLES) ? SEED_W : INIT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(SEED_W - 1);
    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES - 1);

    // IDLE: waiting for first seed | LOAD: serial shift-in | INIT: init feedback | RUN: free running
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        INIT = 2'd2,
        RUN  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [SEED_W-1:0] sr_q, sr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              seed_rdy;
    logic              accept;
    logic [SEED_W-1:0] seed_in;

    assign seed_rdy           = (state_q == IDLE) || (state_q == RUN);
    assign seed_if.seed_ready = seed_rdy;
    assign accept             = seed_if.seed_valid && seed_rdy;

`ifdef NLFSR_SEED_ZERO_GUARD_EN
    logic seed_zero;
    logic zero_flag_q;

    // An all-zero NLFSR state can lock up, so substitute the smallest non-zero seed.
    assign seed_zero      = (seed_if.seed == '0);
    assign seed_in        = seed_zero ? SEED_W'(1) : seed_if.seed;
    assign zero_seed_flag = zero_flag_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_flag_q <= 1'b0;
        end else begin
            zero_flag_q <= accept && seed_zero;
        end
    end
`else
    assign seed_in = seed_if.seed;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        d_o     = 1'b0;
        load_o  = 1'b0;
        init_o  = 1'b0;
        ce_o    = 1'b0;
        running = 1'b0;
        busy    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    sr_d    = seed_in;
                    cnt_d   = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                load_o = 1'b1;
                busy   = 1'b1;
                d_o    = sr_q[0];
                sr_d   = sr_q >> 1;
                if (cnt_q == LOAD_LAST) begin
                    cnt_d   = '0;
                    state_d = INIT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            INIT: begin
                busy = 1'b1;
                if (cnt_q == INIT_LAST) begin
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                init_o  = 1'b1;
                running = 1'b1;
                ce_o    = run_en;
                // Reseed restarts the whole load/init sequence from the new word.
                if (accept) begin
                    sr_d    = seed_in;
                    cnt_d   = '0;
                    state_d = LOAD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    a_load_busy: assert property (@(posedge clk) disable iff (rst) load_o |-> busy);
    a_ready_busy: assert property (@(posedge clk) disable iff (rst) seed_rdy == !busy);
    a_ce_run: assert property (@(posedge clk) disable iff (rst) ce_o |-> running);
    a_run_init: assert property (@(posedge clk) disable iff (rst) running == init_o);
endmodule

// File: doc/nlfsr_seed_loader.md
Name: nlfsr_seed_loader

Overview:
- Driver side of the NLFSR serial seed/init interface (the `load`, `d`, `init` and clock-enable inputs of each NLFSR).
- Accepts a parallel seed word over a valid/ready handshake and shifts it into the NLFSR bit-serially, LSB first.
- Then holds the NLFSR in its initialisation-feedback phase for a fixed number of cycles, and finally releases it to run mode.
- One instance per NLFSR lane; sits between the TRNG top-level control and the NLFSR.

Parameters:
- SEED_W, 16: seed width and number of load shifts; equals the target NLFSR length.
- INIT_CYCLES, 32: cycles spent in the initialisation phase after loading; must be ≥1.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- seed  input  SEED_W  parallel seed; sampled on the handshake cycle.
- seed_valid  input  1  seed offered.
- seed_ready  output  1  loader can accept a seed.
- run_en  input  1  run-phase step enable from the lane scheduler.
- d_o  output  1  serial seed bit to the NLFSR `d` input.
- load_o  output  1  NLFSR load select; 1 selects `d_o` as shift-in.
- init_o  output  1  NLFSR feedback select; 0 selects init feedback, 1 selects run feedback.
- ce_o  output  1  NLFSR run-phase clock enable.
- running  output  1  NLFSR in run mode; output stream valid.
- busy  output  1  in LOAD or INIT.

Behaviour:
- Reset values: state IDLE, load_o=0, init_o=0, d_o=0, ce_o=0, running=0, busy=0, seed_ready=1, shift register and counters 0.
- States are IDLE, LOAD, INIT and RUN. Handshake occurs when seed_valid && seed_ready in the same cycle.
- seed_ready is 1 in IDLE and RUN, and 0 in LOAD and INIT.
- IDLE:
  - On handshake, capture seed into shift register sr, clear bit counter, go to LOAD next cycle.
  - Outputs stay at reset values.
- LOAD:
  - load_o=1, init_o=0, ce_o=0, busy=1.
  - d_o=sr[0] combinationally from the registered sr.
  - Each cycle: sr shifts right by 1 and cnt increments.
  - Exactly SEED_W cycles with load_o=1. Bit k of the seed is presented on the k-th LOAD cycle (k=0 first).
  - After the SEED_W-th cycle, go to INIT and clear cnt.
  - Net effect: seed[i] ends up in NLFSR b[i].
- INIT:
  - load_o=0, init_o=0, ce_o=0, d_o=0, busy=1.
  - Exactly INIT_CYCLES cycles, then go to RUN.
- RUN:
  - load_o=0, init_o=1, running=1, busy=0, ce_o=run_en (combinational pass-through, registered state).
  - A handshake in RUN is a reseed: capture seed, go to LOAD next cycle.
  - running drops to 0 in the first LOAD cycle.
- Counter width is $clog2(max(SEED_W, INIT_CYCLES)+1). The counter never wraps; terminal compare is equality.
- Simultaneous events:
  - seed_valid in LOAD or INIT is ignored (seed_ready=0) and no data is lost from the upstream view.
  - run_en outside RUN has no effect (ce_o=0).
- Reset mid-operation: immediate return to IDLE with reset values. A partially loaded seed is discarded and the NLFSR reset handles its own state.
- No back-to-back accept from IDLE: the earliest next handshake is in RUN.

Optional Feature:
- Macro: NLFSR_SEED_ZERO_GUARD_EN.
- With the macro defined:
  - An all-zero seed at handshake is replaced by the constant {SEED_W{1'b0}} | 1 (LSB=1).
  - Extra output `zero_seed_flag` pulses high for exactly one cycle on that handshake.
  - The flag resets to 0.
- Without the macro: seed is loaded verbatim, and the port and logic are absent.

Test Plan:
- Reset then seed=16'hA5C3 in IDLE:
  - seed_ready=0 next cycle.
  - load_o=1 for exactly 16 cycles with d_o = 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1.
  - Then init_o=0, load_o=0 for exactly 32 cycles.
  - Then running=1, init_o=1.
- RUN with run_en toggling 1,0,1,1 → ce_o follows 1,0,1,1 the same cycles; load_o stays 0.
- seed_valid held high with seed=16'hFFFF during LOAD/INIT of a previous seed:
  - No accept.
  - d_o sequence matches the first seed only.
  - Accept occurs on the first RUN cycle.
- Reseed in RUN with seed=16'h0001:
  - running=0 the next cycle.
  - d_o = 1 then fifteen 0s.
  - 32 INIT cycles, then running=1.
- Assert rst on the 7th LOAD cycle:
  - All outputs return to reset values immediately (asynchronous), seed_ready=1.
  - After release, a new seed 16'h1234 loads from bit 0.
- With NLFSR_SEED_ZERO_GUARD_EN, seed=16'h0000:
  - zero_seed_flag=1 for one cycle.
  - d_o = 1 then fifteen 0s.
  - Without the macro, d_o is sixteen 0s.
